// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: one access per 3 cycles,
// port 0 preferred with a bounded wait for port 1. Optional counters: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       starve_cnt
`endif
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          owner;
  logic [CW-1:0] wait_cnt;
  logic          force1;
  logic          grant1;

  // port 1 wins when alone, or when port 0 has used up its consecutive-grant budget
  assign force1 = req0 & req1 & (wait_cnt == WAIT_MAX);
  assign grant1 = req1 & (~req0 | force1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      owner    <= 1'b0;
      wait_cnt <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      busy     <= 1'b0;
      mem_A    <= '0;
      mem_WD   <= '0;
      mem_WE   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_WE <= 1'b0;
          if (!req1 || grant1) wait_cnt <= '0;
          else                 wait_cnt <= wait_cnt + 1'b1;
          if (req0 || req1) begin
            owner  <= grant1;
            mem_A  <= grant1 ? addr1  : addr0;
            mem_WD <= grant1 ? wdata1 : wdata0;
            mem_WE <= grant1 ? we1    : we0;
            busy   <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          // memory acted at the mid-cycle negedge; mem_WE low here means it was a read
          mem_WE <= 1'b0;
          if (!mem_WE) begin
            if (owner) rdata1 <= mem_RD;
            else       rdata0 <= mem_RD;
          end
          ack0  <= ~owner;
          ack1  <= owner;
          state <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          busy   <= 1'b0;
          mem_WE <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conflict_cnt <= '0;
      starve_cnt   <= '0;
    end else if (state == IDLE) begin
      if (req0 && req1 && conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 32'd1;
      if (force1 && starve_cnt != 32'hFFFF_FFFF)         starve_cnt   <= starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (arbitration rule + reference memory image).
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mem_WE;
  logic [DW-1:0] rdata0, rdata1, mem_WD, mem_RD;
  logic [AW-1:0] mem_A;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   conflict_cnt, starve_cnt;
`endif

  logic          mem_init = 1'b0;
  logic [31:0]   mem     [0:255];
  logic [31:0]   ref_mem [0:255];
  int            tests = 0;
  int            fails = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .starve_cnt(starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // data memory: samples on negedge, registered read data
  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_WE) mem[mem_A[9:2]] <= mem_WD;
      mem_RD <= mem[mem_A[9:2]];
    end
  end

  task automatic do_reset(input bit init);
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    resetn = 0; mem_init = init;
    repeat (2) @(negedge clk);
    mem_init = 0; resetn = 1;
  endtask

  task automatic test_reset();
    resetn = 0; mem_init = 1;
    @(negedge clk);
    tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b0) begin
      fails++; $display("FAIL reset_ctl: got %b want 0000", {ack0, ack1, busy, mem_WE});
    end
    tests++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      fails++; $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1);
    end
    tests++;
    if (mem_A !== 32'h0 || mem_WD !== 32'h0) begin
      fails++; $display("FAIL reset_mem: got A=%h WD=%h want 0/0", mem_A, mem_WD);
    end
    @(negedge clk);
    mem_init = 0; resetn = 1;
  endtask

  task automatic test_read();
    int lat = 0; bit saw_we = 0, saw_a1 = 0;
    req0 = 1; addr0 = 32'h10; we0 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mem_WE) saw_we = 1;
      if (ack1) saw_a1 = 1;
      if (ack0) begin lat = i; break; end
    end
    req0 = 0;
    tests++;
    if (lat != 2) begin fails++; $display("FAIL read_lat: got %0d want 2", lat); end
    tests++;
    if (rdata0 !== 32'hDEADBEEF) begin fails++; $display("FAIL read_data: got %h want deadbeef", rdata0); end
    tests++;
    if (saw_we || saw_a1) begin fails++; $display("FAIL read_side: we=%0b ack1=%0b want 0/0", saw_we, saw_a1); end
    @(negedge clk);
    tests++;
    if ({ack0, busy} !== 2'b00) begin fails++; $display("FAIL read_pulse: ack0,busy=%b want 00", {ack0, busy}); end
  endtask

  task automatic test_write();
    int lat = 0, we_cyc = 0; bit a_ok = 1;
    req1 = 1; addr1 = 32'h40; wdata1 = 32'h12345678; we1 = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mem_WE) begin
        we_cyc++;
        if (mem_A !== 32'h40 || mem_WD !== 32'h12345678) a_ok = 0;
      end
      if (ack1) begin lat = i; break; end
    end
    req1 = 0; we1 = 0;
    tests++;
    if (we_cyc != 1 || !a_ok) begin fails++; $display("FAIL write_we: cycles=%0d addr_ok=%0b want 1/1", we_cyc, a_ok); end
    tests++;
    if (lat != 2) begin fails++; $display("FAIL write_lat: got %0d want 2", lat); end
    tests++;
    if (mem[16] !== 32'h12345678) begin fails++; $display("FAIL write_mem: got %h want 12345678", mem[16]); end
    @(negedge clk);
    req0 = 1; addr0 = 32'h40; we0 = 0; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack0) begin lat = i; break; end
    end
    req0 = 0;
    tests++;
    if (lat != 2 || rdata0 !== 32'h12345678 || rdata1 !== 32'h0) begin
      fails++; $display("FAIL readback: lat=%0d rdata0=%h rdata1=%h want 2/12345678/0", lat, rdata0, rdata1);
    end
    @(negedge clk);
  endtask

  task automatic test_both();
    int order[$]; int last = -1, gap_bad = 0;
    do_reset(1);
    req0 = 1; addr0 = 32'h4; we0 = 0;
    req1 = 1; addr1 = 32'h8; we1 = 0;
    for (int cyc = 1; cyc <= 200 && order.size() < 15; cyc++) begin
      @(negedge clk);
      if (ack0 && ack1) gap_bad++;
      if (ack0 || ack1) begin
        order.push_back(ack1 ? 1 : 0);
        if (last >= 0 && cyc - last != 3) gap_bad++;
        last = cyc;
      end
    end
    req0 = 0; req1 = 0;
    tests++;
    if (order.size() != 15) begin fails++; $display("FAIL both_count: got %0d want 15", order.size()); end
    foreach (order[i]) begin
      tests++;
      if (order[i] != ((i % (MW + 1) == MW) ? 1 : 0)) begin
        fails++; $display("FAIL both_order[%0d]: got port %0d want port %0d", i, order[i], (i % (MW + 1) == MW) ? 1 : 0);
      end
    end
    tests++;
    if (gap_bad != 0) begin fails++; $display("FAIL both_spacing: bad=%0d want 0", gap_bad); end
    tests++;
    if (rdata0 !== init_val(1) || rdata1 !== init_val(2)) begin
      fails++; $display("FAIL both_data: got %h/%h want %h/%h", rdata0, rdata1, init_val(1), init_val(2));
    end
    @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
    tests++;
    if (starve_cnt !== 32'd3 || conflict_cnt !== 32'd15) begin
      fails++; $display("FAIL stats: starve=%0d conflict=%0d want 3/15", starve_cnt, conflict_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit saw_ack = 0;
    req0 = 1; addr0 = 32'h80; wdata0 = 32'hCAFEF00D; we0 = 1;
    @(posedge clk); #1;
    tests++;
    if (mem_WE !== 1'b1 || mem_A !== 32'h80) begin
      fails++; $display("FAIL rst_launch: we=%b A=%h want 1/80", mem_WE, mem_A);
    end
    resetn = 0; #1;
    tests++;
    if ({mem_WE, busy} !== 2'b00) begin fails++; $display("FAIL rst_async: we,busy=%b want 00", {mem_WE, busy}); end
    req0 = 0; we0 = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack0 || ack1) saw_ack = 1;
    end
    tests++;
    if (saw_ack || busy !== 1'b0) begin fails++; $display("FAIL rst_after: ack=%0b busy=%b want 0/0", saw_ack, busy); end
    tests++;
    if (mem[32] !== init_val(32)) begin fails++; $display("FAIL rst_mem: got %h want %h", mem[32], init_val(32)); end
  endtask

  task automatic test_drop();
    req1 = 1; addr1 = 32'hC; we1 = 0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL drop_busy: got %b want 1", busy); end
    req1 = 0;
    @(negedge clk);
    tests++;
    if (ack1 !== 1'b1 || rdata1 !== init_val(3)) begin
      fails++; $display("FAIL drop_ack: ack1=%b rdata1=%h want 1/%h", ack1, rdata1, init_val(3));
    end
    @(negedge clk);
    tests++;
    if ({ack1, busy} !== 2'b00) begin fails++; $display("FAIL drop_idle: ack1,busy=%b want 00", {ack1, busy}); end
  endtask

  task automatic test_resp_ignore();
    int lat = 0; bit got0 = 0; logic b1 = 1'b1;
    req0 = 1; addr0 = 32'h14; we0 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack0) begin got0 = 1; break; end
    end
    req0 = 0;
    req1 = 1; addr1 = 32'h18; we1 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) b1 = busy;
      if (ack1) begin lat = i; break; end
    end
    req1 = 0;
    tests++;
    if (!got0 || b1 !== 1'b0 || lat != 3) begin
      fails++; $display("FAIL resp_ignore: ack0=%0b busy=%b lat=%0d want 1/0/3", got0, b1, lat);
    end
    tests++;
    if (rdata0 !== init_val(5) || rdata1 !== init_val(6)) begin
      fails++; $display("FAIL resp_data: got %h/%h want %h/%h", rdata0, rdata1, init_val(5), init_val(6));
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int next_free = 0, wcnt = 0, ack_edge = -1, ack_port = 0;
    bit ack_rd = 0, p0 = 0, p1 = 0, g1, e0, e1;
    logic [31:0] ack_val = 0, x0 = 0, x1 = 0;
    logic [7:0] idx;
    do_reset(1);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int e = 0; e < 2000; e++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1; addr0 = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
        wdata0 = $urandom; we0 = 1'($urandom_range(0, 1));
      end
      if (!p1 && $urandom_range(0, 1) != 0) begin
        p1 = 1; addr1 = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
        wdata1 = $urandom; we1 = 1'($urandom_range(0, 1));
      end
      req0 = p0; req1 = p1;
      // arbitration decision for the coming edge if the memory is free then
      if (e >= next_free) begin
        if (!p1) wcnt = 0;
        if (p0 || p1) begin
          g1 = p1 && (!p0 || wcnt == MW);
          if (g1) wcnt = 0; else if (p1) wcnt++;
          ack_edge = e + 1; ack_port = g1 ? 1 : 0;
          ack_rd = g1 ? !we1 : !we0;
          idx = g1 ? addr1[9:2] : addr0[9:2];
          if (ack_rd) ack_val = ref_mem[idx];
          else        ref_mem[idx] = g1 ? wdata1 : wdata0;
          next_free = e + 3;
        end
      end
      @(posedge clk);
      @(negedge clk);
      e0 = (ack_edge == e) && (ack_port == 0);
      e1 = (ack_edge == e) && (ack_port == 1);
      if (e0 && ack_rd) x0 = ack_val;
      if (e1 && ack_rd) x1 = ack_val;
      tests++;
      if (ack0 !== e0 || ack1 !== e1 || rdata0 !== x0 || rdata1 !== x1) begin
        fails++;
        $display("FAIL rand@%0d: ack=%b%b rd=%h/%h want ack=%b%b rd=%h/%h",
                 e, ack0, ack1, rdata0, rdata1, e0, e1, x0, x1);
      end
      if (e0) p0 = 0;
      if (e1) p1 = 0;
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_both();
    test_reset_mid();
    test_drop();
    test_resp_ignore();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
